// File: rtl/nmea_pkg.sv
// ============================================================================
// nmea_pkg : parser states, ASCII delimiters and the GGA header bytes
// Rev 1.0
// ============================================================================
`default_nettype none

package nmea_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR    = 3'd1,
    FIELDS = 3'd2,
    CK_HI  = 3'd3,
    CK_LO  = 3'd4
  } state_t;

  localparam logic [7:0] DOLLAR    = 8'h24;
  localparam logic [7:0] COMMA     = 8'h2C;
  localparam logic [7:0] STAR      = 8'h2A;
  localparam int         LAT_SLOTS = 10;

  // "GPGGA", indexed by position after the '$'
  function automatic logic [7:0] hdr_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    hdr_byte = 8'h47;
      3'd1:    hdr_byte = 8'h50;
      3'd2:    hdr_byte = 8'h47;
      3'd3:    hdr_byte = 8'h47;
      3'd4:    hdr_byte = 8'h41;
      default: hdr_byte = 8'h00;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/hex_nibble_decode.sv
// ============================================================================
// hex_nibble_decode : uppercase ASCII hex digit to 4-bit nibble with valid flag
// Rev 1.0
// ============================================================================
`default_nettype none

module hex_nibble_decode (
  input  logic [7:0] ascii,
  output logic [3:0] nibble,
  output logic       valid
);

  always_comb begin
    nibble = 4'h0;
    valid  = 1'b0;
    if (ascii >= 8'h30 && ascii <= 8'h39) begin
      nibble = ascii[3:0];
      valid  = 1'b1;
    end else if (ascii >= 8'h41 && ascii <= 8'h46) begin
      nibble = ascii[3:0] + 4'd9;
      valid  = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/nmea_lat_parser.sv
// ============================================================================
// nmea_lat_parser : extracts the latitude field of checksum-valid $GPGGA lines
// Rev 1.0
// ============================================================================
`default_nettype none

module nmea_lat_parser
  import nmea_pkg::*;
#(
  parameter int MAX_SENT = 82
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       new_fix,
  output logic [7:0] lat0,
  output logic [7:0] lat1,
  output logic [7:0] lat2,
  output logic [7:0] lat3,
  output logic [7:0] lat4,
  output logic [7:0] lat5,
  output logic [7:0] lat6,
  output logic [7:0] lat7,
  output logic [7:0] lat8,
  output logic [7:0] lat9,
  output logic [3:0] lat_len
);

  localparam int CNT_W = $clog2(MAX_SENT + 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [6:0]       fld, fld_n;
  logic [7:0]       xsum, xsum_n;
  logic [3:0]       hi, hi_n;
  logic [3:0]       len_sh, len_sh_n;
  logic [7:0]       sh   [LAT_SLOTS];
  logic [7:0]       sh_n [LAT_SLOTS];
  logic [7:0]       lat  [LAT_SLOTS];
  logic             load;
  logic [3:0]       nib;
  logic             nib_ok;

  hex_nibble_decode u_hex (
    .ascii  (rx_data),
    .nibble (nib),
    .valid  (nib_ok)
  );

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    fld_n    = fld;
    xsum_n   = xsum;
    hi_n     = hi;
    len_sh_n = len_sh;
    sh_n     = sh;
    load     = 1'b0;
    if (rx_valid) begin
      if (rx_data == DOLLAR) begin
        state_n  = HDR;
        cnt_n    = CNT_W'(1);
        fld_n    = 7'd0;
        xsum_n   = 8'h00;
        len_sh_n = 4'd0;
        for (int i = 0; i < LAT_SLOTS; i++) sh_n[i] = 8'h00;
      end else if (state != IDLE && cnt >= CNT_W'(MAX_SENT)) begin
        // this byte would make the sentence longer than MAX_SENT
        state_n = IDLE;
      end else begin
        if (state != IDLE) cnt_n = cnt + CNT_W'(1);
        case (state)
          HDR: begin
            xsum_n = xsum ^ rx_data;
            if (cnt <= CNT_W'(5)) begin
              if (rx_data != hdr_byte(3'(cnt - CNT_W'(1)))) state_n = IDLE;
            end else if (rx_data == COMMA) begin
              state_n = FIELDS;
              fld_n   = 7'd1;
            end else begin
              state_n = IDLE;
            end
          end
          FIELDS: begin
            if (rx_data == STAR) begin
              state_n = CK_HI;
            end else begin
              xsum_n = xsum ^ rx_data;
              if (rx_data == COMMA) begin
                if (fld != 7'h7F) fld_n = fld + 7'd1;
              end else if (fld == 7'd2 && len_sh < 4'(LAT_SLOTS)) begin
                sh_n[len_sh] = rx_data;
                len_sh_n     = len_sh + 4'd1;
              end
            end
          end
          CK_HI: begin
            if (nib_ok) begin
              hi_n    = nib;
              state_n = CK_LO;
            end else begin
              state_n = IDLE;
            end
          end
          CK_LO: begin
            state_n = IDLE;
            if (nib_ok && {hi, nib} == xsum) load = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      fld     <= '0;
      xsum    <= '0;
      hi      <= '0;
      len_sh  <= '0;
      new_fix <= 1'b0;
      lat_len <= '0;
      for (int i = 0; i < LAT_SLOTS; i++) begin
        sh[i]  <= 8'h00;
        lat[i] <= 8'h00;
      end
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      fld     <= fld_n;
      xsum    <= xsum_n;
      hi      <= hi_n;
      len_sh  <= len_sh_n;
      sh      <= sh_n;
      new_fix <= load;
      if (load) begin
        lat     <= sh;
        lat_len <= len_sh;
      end
    end
  end

  assign lat0 = lat[0];
  assign lat1 = lat[1];
  assign lat2 = lat[2];
  assign lat3 = lat[3];
  assign lat4 = lat[4];
  assign lat5 = lat[5];
  assign lat6 = lat[6];
  assign lat7 = lat[7];
  assign lat8 = lat[8];
  assign lat9 = lat[9];

endmodule

`default_nettype wire

// File: tb/tb_nmea_lat_parser.sv
// ============================================================================
// tb_nmea_lat_parser : directed sentences against hand-derived latitude results
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_nmea_lat_parser;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       new_fix;
  logic [7:0] lat [10];
  logic [3:0] lat_len;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int pulses    = 0;
  int wide      = 0;
  logic prev_fix = 1'b0;

  always #5 clk = ~clk;

  nmea_lat_parser #(.MAX_SENT(82)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .new_fix  (new_fix),
    .lat0     (lat[0]),
    .lat1     (lat[1]),
    .lat2     (lat[2]),
    .lat3     (lat[3]),
    .lat4     (lat[4]),
    .lat5     (lat[5]),
    .lat6     (lat[6]),
    .lat7     (lat[7]),
    .lat8     (lat[8]),
    .lat9     (lat[9]),
    .lat_len  (lat_len)
  );

  always @(negedge clk) begin
    if (new_fix) begin
      pulses++;
      if (prev_fix) wide++;
    end
    prev_fix = new_fix;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic string with_ck(input string body);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < body.len(); i++) x ^= body[i];
    return {"$", body, "*", $sformatf("%02X", x)};
  endfunction

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = s[i];
      repeat (gap) begin
        @(negedge clk);
        rx_valid = 1'b0;
      end
    end
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_lat(input string tag, input string exp);
    logic [7:0] c;
    check({tag, "_len"}, 32'(lat_len), 32'(exp.len()));
    for (int i = 0; i < exp.len(); i++) begin
      c = exp[i];
      check($sformatf("%s_lat%0d", tag, i), 32'(lat[i]), 32'(c));
    end
  endtask

  initial begin
    int    p0;
    string s;
    string pad;

    rst      = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_fix", 32'(new_fix), 0);
    check("rst_len", 32'(lat_len), 0);
    check("rst_lat0", 32'(lat[0]), 0);
    check("rst_lat9", 32'(lat[9]), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // reference GGA line
    p0 = pulses;
    send_str("$GPGGA,123519,4807.038,N,01131.000,E,1,08,0.9,545.4,M,46.9,M,,*47", 0);
    check("gga_pulse", 32'(pulses - p0), 1);
    check_lat("gga", "4807.038");

    // wrong checksum: nothing changes
    p0 = pulses;
    send_str("$GPGGA,123519,4807.038,N,01131.000,E,1,08,0.9,545.4,M,46.9,M,,*48", 1);
    check("badck_pulse", 32'(pulses - p0), 0);
    check_lat("badck", "4807.038");

    // empty latitude field; shadow was cleared so slot 0 reads 0x00
    p0 = pulses;
    send_str(with_ck("GPGGA,123519,,N,01131.000,E,1,08"), 0);
    check("empty_pulse", 32'(pulses - p0), 1);
    check("empty_len", 32'(lat_len), 0);
    check("empty_lat0", 32'(lat[0]), 0);

    // 12-char latitude saturates at 10 stored chars
    p0 = pulses;
    send_str(with_ck("GPGGA,123519,480703812345,N,1"), 0);
    check("long_pulse", 32'(pulses - p0), 1);
    check_lat("long", "4807038123");

    // RMC ignored, interrupted GGA dropped, final GGA accepted
    p0 = pulses;
    send_str(with_ck("GPRMC,123519,A,4807.038,N,01131.000,E"), 0);
    send_str("$GPGGA,123519,49", 0);
    send_str(with_ck("GPGGA,123519,5123.456,S,1,08"), 0);
    check("inject_pulse", 32'(pulses - p0), 1);
    check_lat("inject", "5123.456");

    // only one comma: still valid, no latitude
    p0 = pulses;
    send_str(with_ck("GPGGA,123519"), 0);
    check("onecomma_pulse", 32'(pulses - p0), 1);
    check("onecomma_len", 32'(lat_len), 0);

    // bad hex character in checksum
    p0 = pulses;
    send_str("$GPGGA,1,2233.44*G0", 0);
    check("badhex_pulse", 32'(pulses - p0), 0);

    // exactly 82 chars accepted, 83 chars rejected
    pad = "GPGGA,1,4807.038,N,";
    while (pad.len() < 78) pad = {pad, "0"};
    s = with_ck(pad);
    check("len82_size", 32'(s.len()), 82);
    p0 = pulses;
    send_str(s, 0);
    check("len82_pulse", 32'(pulses - p0), 1);
    check_lat("len82", "4807.038");
    pad = "GPGGA,1,1111.111,N,";
    while (pad.len() < 79) pad = {pad, "0"};
    p0 = pulses;
    send_str(with_ck(pad), 0);
    check("len83_pulse", 32'(pulses - p0), 0);
    check_lat("len83", "4807.038");

    // asynchronous reset between strobes mid-sentence
    s = with_ck("GPGGA,123519,3344.556,N,1,08");
    p0 = pulses;
    send_str(s.substr(0, 15), 0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_len", 32'(lat_len), 0);
    check("arst_lat0", 32'(lat[0]), 0);
    check("arst_fix", 32'(new_fix), 0);
    @(negedge clk);
    rst = 1'b0;
    send_str(s.substr(16, s.len() - 1), 0);
    check("arst_pulse", 32'(pulses - p0), 0);
    check("arst_hold", 32'(lat_len), 0);

    check("fix_width", 32'(wide), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
